shift_data_path: RTL and testbench
==================================

SHIFT_DATA_PATH -- requirements
Module: shift_data_path

Interface
REQ-001 Parameter: DATA_W, default 32, width in bits of one data word.
REQ-002 Parameter: LINE_WORDS, default 4, data words per image line; legal range 2..1024.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 Port: write_en  input  1  high: shift data_in into the window on this clock edge; low: hold.
REQ-006 Port: data_in  input  DATA_W  new pixel word; sampled only when write_en=1.
REQ-007 Port: w0  output  DATA_W  newest word, current line.
REQ-008 Port: w1  output  DATA_W  word before w0, current line.
REQ-009 Port: w2  output  DATA_W  word at w0's position, one line earlier.
REQ-010 Port: w3  output  DATA_W  word at w1's position, one line earlier.
REQ-011 Port: w4  output  DATA_W  word at w0's position, two lines earlier.
REQ-012 Port: w5  output  DATA_W  word at w1's position, two lines earlier.
REQ-013 Port: window_valid  output  1  high once the chain holds 2*LINE_WORDS+2 written words since reset.

Function
REQ-014 Internally the block SHALL hold a word chain s[0..2*LINE_WORDS+1], each entry DATA_W bits.
REQ-015 On a rising edge with reset=0 and write_en=1: s[0]<=data_in and s[i]<=s[i-1] for all i>=1, all in the same cycle.
REQ-016 On a rising edge with reset=0 and write_en=0: every s[i], window_valid and the fill count SHALL hold.
REQ-017 Taps SHALL be registered values with no combinational path from data_in: w0=s[0], w1=s[1], w2=s[LINE_WORDS], w3=s[LINE_WORDS+1], w4=s[2*LINE_WORDS], w5=s[2*LINE_WORDS+1].
REQ-018 Latency: a word written on edge k SHALL appear on w0 immediately after edge k, on w2 after LINE_WORDS writes, and on w4 after 2*LINE_WORDS writes.
REQ-019 A fill counter SHALL increment on each write and saturate at 2*LINE_WORDS+2; window_valid = (count == 2*LINE_WORDS+2).
REQ-020 Once set, window_valid SHALL remain high until reset, regardless of how long write_en stays low.
REQ-021 No wrap-around or line-boundary logic: the chain is a pure word shift, and line alignment is the writer's responsibility.

Reset
REQ-022 When reset=1 at a rising edge, all s[i], w0..w5 and the fill count SHALL become 0 and window_valid SHALL become 0.
REQ-023 Reset SHALL take priority over write_en; the write on that edge is discarded, including a reset asserted mid-fill.
REQ-024 The first write after reset deassertion SHALL be treated as write number 1.

Structure
REQ-025 A shared package SHALL hold DATA_W, the default LINE_WORDS and the derived constant CHAIN_LEN=2*LINE_WORDS+2.
REQ-026 One sub-module, line_delay, SHALL be used, instantiated twice in series: a LINE_WORDS-deep word delay with enable and synchronous reset.
REQ-027 The s[0..1] and s[LINE_WORDS..LINE_WORDS+1] taps SHALL be taken from the line_delay instances' input and output stages.

Verification (LINE_WORDS=4, DATA_W=32)
REQ-028 Hold reset=1 for 2 cycles -> w0..w5=0, window_valid=0.
REQ-029 Write 1..10 on consecutive cycles -> w0=10, w1=9, w2=6, w3=5, w4=2, w5=1; window_valid rises on write 10, not on write 9.
REQ-030 Alternate write_en 0/1 while data_in increments each cycle from 0 -> only the values sampled while write_en=1 enter the chain, and outputs hold on idle cycles.
REQ-031 After 10 writes, hold write_en=0 for 20 cycles -> all outputs and window_valid unchanged.
REQ-032 Write 1..5, assert reset with write_en=1 and data_in=99, then write 7 -> outputs are 0 after reset; afterwards w0=7 and w1..w5=0, window_valid=0.
REQ-033 Write 0xFFFFFFFF then 0 -> w1=0xFFFFFFFF and w0=0, confirming full-width transfer with no truncation.

Source files
------------

// File: rtl/shift_data_path_pkg.sv
// Shared constants for the shift_data_path sliding-window slice.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package shift_data_path_pkg;

    // Width of one pixel word.
    localparam int DATA_W     = 32;
    // Default number of words per image line.
    localparam int LINE_WORDS = 4;

    // Chain length: two full lines plus the two taps of the oldest line.
    function automatic int chain_len(input int line_words);
        return 2 * line_words + 2;
    endfunction

    localparam int CHAIN_LEN = chain_len(LINE_WORDS);

endpackage

// File: rtl/shift_data_path_line_delay.sv
// line_delay: DEPTH-deep word delay line with enable and synchronous reset.
// Latency: a word enters the head on its enable edge; it reaches tail after DEPTH-1 more enables.
// Backpressure: none; en low freezes every stage.
// Ports: clk, reset (sync, active-high), en, din -> head (stage 0), head_next (stage 1), tail (stage DEPTH-1).
module line_delay #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [DATA_W-1:0] head_next,
    output logic [DATA_W-1:0] tail
);

    logic [DATA_W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign head      = stage[0];
    assign head_next = stage[1];
    assign tail      = stage[DEPTH-1];

endmodule

// File: rtl/shift_data_path.sv
// shift_data_path: 3-line x 2-word sliding window over a pixel word stream.
// Latency: data_in appears on w0 right after its write edge; on w2 after LINE_WORDS writes, on w4 after 2*LINE_WORDS.
// Backpressure: none; write_en low holds the whole window and the fill state.
// Ports: clk, reset (sync, active-high), write_en, data_in -> w0..w5 window taps, window_valid.
module shift_data_path
    import shift_data_path_pkg::*;
#(
    parameter int DATA_W     = shift_data_path_pkg::DATA_W,
    parameter int LINE_WORDS = shift_data_path_pkg::LINE_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] w0,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] w3,
    output logic [DATA_W-1:0] w4,
    output logic [DATA_W-1:0] w5,
    output logic              window_valid
);

    localparam int CHAIN = chain_len(LINE_WORDS);
    localparam int CNT_W = $clog2(CHAIN + 1);

    // Chain layout: s[0..L-1] in line0, s[L..2L-1] in line1, s[2L], s[2L+1] in top registers.
    logic [DATA_W-1:0] l0_head, l0_head_next, l0_tail;
    logic [DATA_W-1:0] l1_head, l1_head_next, l1_tail;
    logic [DATA_W-1:0] s_2l, s_2l_p1;
    logic [CNT_W-1:0]  fill_cnt;

    line_delay #(.DATA_W(DATA_W), .DEPTH(LINE_WORDS)) u_line0 (
        .clk       (clk),
        .reset     (reset),
        .en        (write_en),
        .din       (data_in),
        .head      (l0_head),
        .head_next (l0_head_next),
        .tail      (l0_tail)
    );

    line_delay #(.DATA_W(DATA_W), .DEPTH(LINE_WORDS)) u_line1 (
        .clk       (clk),
        .reset     (reset),
        .en        (write_en),
        .din       (l0_tail),
        .head      (l1_head),
        .head_next (l1_head_next),
        .tail      (l1_tail)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s_2l     <= '0;
            s_2l_p1  <= '0;
            fill_cnt <= '0;
        end else if (write_en) begin
            s_2l    <= l1_tail;
            s_2l_p1 <= s_2l;
            // Saturate so window_valid stays up for the rest of the stream.
            if (fill_cnt != CNT_W'(CHAIN)) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
        end
    end

    assign w0           = l0_head;
    assign w1           = l0_head_next;
    assign w2           = l1_head;
    assign w3           = l1_head_next;
    assign w4           = s_2l;
    assign w5           = s_2l_p1;
    assign window_valid = (fill_cnt == CNT_W'(CHAIN));

endmodule

// File: tb/tb_shift_data_path.sv
// Self-checking bench for shift_data_path (LINE_WORDS=4, DATA_W=32).
// Latency: outputs are checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_shift_data_path;

    localparam int DW    = 32;
    localparam int LW    = 4;
    localparam int CHAIN = 2 * LW + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] w0, w1, w2, w3, w4, w5;
    logic          window_valid;

    shift_data_path #(.DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_en     (write_en),
        .data_in      (data_in),
        .w0           (w0),
        .w1           (w1),
        .w2           (w2),
        .w3           (w3),
        .w4           (w4),
        .w5           (w5),
        .window_valid (window_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: history of written words since reset, newest first.
    logic [DW-1:0] hist[$];
    int            n_writes = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word written k writes ago (k=0 newest); zero if fewer words were written.
    function automatic logic [DW-1:0] ago(input int k);
        return (k < hist.size()) ? hist[k] : '0;
    endfunction

    task automatic check_model();
        check_val("w0", w0, ago(0));
        check_val("w1", w1, ago(1));
        check_val("w2", w2, ago(LW));
        check_val("w3", w3, ago(LW + 1));
        check_val("w4", w4, ago(2 * LW));
        check_val("w5", w5, ago(2 * LW + 1));
        check_val("window_valid", {31'd0, window_valid}, (n_writes >= CHAIN) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input logic r, input logic we, input logic [DW-1:0] d);
        reset    = r;
        write_en = we;
        data_in  = d;
        @(posedge clk);
        if (r) begin
            hist.delete();
            n_writes = 0;
        end else if (we) begin
            hist.push_front(d);
            if (hist.size() > CHAIN) void'(hist.pop_back());
            n_writes++;
        end
        #1;
        check_model();
    endtask

    logic [DW-1:0] snap [6];
    logic          snap_v;

    initial begin
        // Reset held for two cycles.
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h1234);
        check_val("rst_w0", w0, 32'd0);
        check_val("rst_valid", {31'd0, window_valid}, 32'd0);

        // Consecutive writes 1..10; valid must stay low on write 9.
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, DW'(i));
            if (i == 9) check_val("valid_at_9", {31'd0, window_valid}, 32'd0);
        end
        check_val("fill_w0", w0, 32'd10);
        check_val("fill_w1", w1, 32'd9);
        check_val("fill_w2", w2, 32'd6);
        check_val("fill_w3", w3, 32'd5);
        check_val("fill_w4", w4, 32'd2);
        check_val("fill_w5", w5, 32'd1);
        check_val("valid_at_10", {31'd0, window_valid}, 32'd1);

        // Long idle: everything holds.
        snap = '{w0, w1, w2, w3, w4, w5};
        snap_v = window_valid;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, $urandom);
        check_val("idle_w0", w0, snap[0]);
        check_val("idle_w3", w3, snap[3]);
        check_val("idle_w5", w5, snap[5]);
        check_val("idle_valid", {31'd0, window_valid}, {31'd0, snap_v});

        // Alternating enable with incrementing data.
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 24; i++) step(1'b0, i[0], DW'(i));
        check_val("alt_w0", w0, 32'd23);
        check_val("alt_w1", w1, 32'd21);

        // Reset mid-fill with a write pending.
        step(1'b1, 1'b0, 32'd0);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, DW'(i));
        step(1'b1, 1'b1, 32'd99);
        check_val("midrst_w0", w0, 32'd0);
        check_val("midrst_w1", w1, 32'd0);
        step(1'b0, 1'b1, 32'd7);
        check_val("post_w0", w0, 32'd7);
        check_val("post_w1", w1, 32'd0);
        check_val("post_w5", w5, 32'd0);
        check_val("post_valid", {31'd0, window_valid}, 32'd0);

        // Full-width transfer.
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 32'h0);
        check_val("wide_w1", w1, 32'hFFFF_FFFF);
        check_val("wide_w0", w0, 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
